// File: rtl/toll_pkg.sv
// Shared types and default constants for the toll-gate datapath.
package toll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV    = 2'd1,
        LOOKUP = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W_DEF     = 16;
    localparam int DIST_DEF      = 1000;
    localparam int SPD_LIMIT_DEF = 50;
    localparam int FEE_BASE_DEF  = 10;
    localparam int FEE_FINE_DEF  = 20;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider producing one quotient bit per clock, CNT_W cycles per division.
module serial_divider
    import toll_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic [CNT_W-1:0] quotient,
    output logic             valid
);

    localparam int CW = $clog2(CNT_W) + 1;

    logic [CNT_W-1:0]   rem;
    logic [CNT_W-1:0]   dvs;
    logic [CW-1:0]      cnt;
    logic [2*CNT_W-1:0] nxt;

    // The quotient register doubles as the dividend shifter: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    function automatic logic [2*CNT_W-1:0] div_step(
        input logic [CNT_W-1:0] r,
        input logic [CNT_W-1:0] q,
        input logic [CNT_W-1:0] d
    );
        logic [CNT_W:0] trial;
        trial = {r, q[CNT_W-1]};
        if (trial >= {1'b0, d})
            return {CNT_W'(trial - {1'b0, d}), q[CNT_W-2:0], 1'b1};
        else
            return {trial[CNT_W-1:0], q[CNT_W-2:0], 1'b0};
    endfunction

    // The first step happens on the start edge, straight from the inputs.
    always_comb begin
        nxt = start ? div_step('0, dividend, divisor) : div_step(rem, quotient, dvs);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            valid    <= 1'b0;
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            cnt      <= '0;
        end else begin
            valid <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                dvs             <= divisor;
                {rem, quotient} <= nxt;
                cnt             <= CW'(CNT_W - 1);
                busy            <= 1'b1;
            end else if (busy) begin
                {rem, quotient} <= nxt;
                cnt             <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/toll_datapath.sv
// Toll-gate datapath: transit timer, speed divider, fee lookup, E-pass check
// and lane occupancy, driven by one-hot strobes from the controller FSM.
module toll_datapath
    import toll_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DIST      = DIST_DEF,
    parameter int SPD_LIMIT = SPD_LIMIT_DEF,
    parameter int FEE_BASE  = FEE_BASE_DEF,
    parameter int FEE_FINE  = FEE_FINE_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init,
    input  logic             count,
    input  logic             cal,
    input  logic             up,
    input  logic             down,
    input  logic             epass_tag,
    input  logic [15:0]      epass_balance,
    output logic             valid_Epass,
    output logic [1:0]       num_veh,
    output logic             done,
    output logic [CNT_W-1:0] elapsed,
    output logic [CNT_W-1:0] speed,
    output logic [7:0]       fee,
    output logic             overspeed
);

    state_t           state;
    logic             div_start;
    logic             div_busy;
    logic             div_valid;
    logic [CNT_W-1:0] quotient;
    logic             ovs_next;

    function automatic logic [CNT_W-1:0] sat_inc_time(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [1:0] sat_occupancy(input logic [1:0] n, input logic inc,
                                                 input logic dec);
        if (inc && !dec)
            return (n == 2'd3) ? n : n + 2'd1;
        else if (dec && !inc)
            return (n == 2'd0) ? n : n - 2'd1;
        else
            return n;
    endfunction

    assign div_start = (state == IDLE) && cal && !init && (elapsed != '0);
    assign ovs_next  = speed > CNT_W'(SPD_LIMIT);

    serial_divider #(.CNT_W(CNT_W)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .abort    (init),
        .dividend (CNT_W'(DIST)),
        .divisor  (elapsed),
        .busy     (div_busy),
        .quotient (quotient),
        .valid    (div_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elapsed     <= '0;
            valid_Epass <= 1'b0;
            num_veh     <= 2'd0;
        end else begin
            if (init)
                elapsed <= '0;
            else if (count)
                elapsed <= sat_inc_time(elapsed);

            if (init)
                valid_Epass <= 1'b0;
            else if (count)
                valid_Epass <= epass_tag && (epass_balance >= 16'(FEE_BASE + FEE_FINE));

            num_veh <= sat_occupancy(num_veh, up, down);
        end
    end

    // done is issued the cycle after DONE so it lines up with the held results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            speed     <= '0;
            fee       <= 8'd0;
            overspeed <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (init) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cal) begin
                            if (elapsed == '0) begin
                                speed <= '1;
                                state <= LOOKUP;
                            end else begin
                                state <= DIV;
                            end
                        end
                    end
                    DIV: begin
                        if (div_valid) begin
                            speed <= quotient;
                            state <= LOOKUP;
                        end else if (!div_busy) begin
                            state <= IDLE;
                        end
                    end
                    LOOKUP: begin
                        overspeed <= ovs_next;
                        fee       <= 8'(FEE_BASE) + (ovs_next ? 8'(FEE_FINE) : 8'd0);
                        state     <= DONE;
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_toll_datapath.sv
// Scenario bench for toll_datapath: expected calculation results are queued
// when cal is issued and compared when done arrives.
module tb_toll_datapath;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init, count, cal, up, down, epass_tag;
    logic [15:0] epass_balance;
    logic        valid_Epass, done, overspeed;
    logic [1:0]  num_veh;
    logic [15:0] elapsed, speed;
    logic [7:0]  fee;

    toll_datapath dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .init          (init),
        .count         (count),
        .cal           (cal),
        .up            (up),
        .down          (down),
        .epass_tag     (epass_tag),
        .epass_balance (epass_balance),
        .valid_Epass   (valid_Epass),
        .num_veh       (num_veh),
        .done          (done),
        .elapsed       (elapsed),
        .speed         (speed),
        .fee           (fee),
        .overspeed     (overspeed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int speed;
        int fee;
        int ovs;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   elapsed_model = 0;
    int   occ = 0;

    task automatic pulse_init();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        elapsed_model = 0;
    endtask

    task automatic do_count(input int n);
        count = 1'b1;
        repeat (n) @(negedge clk);
        count = 1'b0;
        elapsed_model = elapsed_model + n;
        if (elapsed_model > 65535) elapsed_model = 65535;
    endtask

    // Reference: plain integer division, all-ones for a zero divisor.
    task automatic push_cal();
        exp_t e;
        e.speed = (elapsed_model == 0) ? 65535 : 1000 / elapsed_model;
        e.ovs   = (e.speed > 50) ? 1 : 0;
        e.fee   = 10 + (e.ovs ? 20 : 0);
        e.due   = cyc + 1 + ((elapsed_model == 0) ? 2 : 18);
        sb.push_back(e);
        cal = 1'b1;
        @(negedge clk);
        cal = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        exp_t e;
        bit   seen;
        int   at;
        seen = 1'b0;
        at   = 0;
        e    = sb.pop_front();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done: done not seen within %0d cycles", tag, budget);
        end else begin
            n_checks++;
            if (at !== e.due) begin
                n_fail++;
                $display("FAIL %s_latency: done at cycle %0d, expected %0d", tag, at, e.due);
            end
            n_checks++;
            if (speed !== 16'(e.speed)) begin
                n_fail++;
                $display("FAIL %s_speed: got %0d, expected %0d", tag, speed, e.speed);
            end
            n_checks++;
            if (fee !== 8'(e.fee) || overspeed !== 1'(e.ovs)) begin
                n_fail++;
                $display("FAIL %s_fee: got fee %0d ovs %0b, expected fee %0d ovs %0d",
                         tag, fee, overspeed, e.fee, e.ovs);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || speed !== 16'(e.speed) || fee !== 8'(e.fee)) begin
                n_fail++;
                $display("FAIL %s_hold: done %0b speed %0d fee %0d, expected 0/%0d/%0d",
                         tag, done, speed, fee, e.speed, e.fee);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        {init, count, cal, up, down, epass_tag} = '0;
        epass_balance = 16'd0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({valid_Epass, num_veh, done, elapsed, speed, fee, overspeed} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: vE %0b nv %0d done %0b el %0d sp %0d fee %0d ovs %0b, expected all 0",
                     valid_Epass, num_veh, done, elapsed, speed, fee, overspeed);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_occupancy();
        for (int i = 0; i < 4; i++) begin
            up = 1'b1;
            @(negedge clk);
            up = 1'b0;
            occ = (occ < 3) ? occ + 1 : 3;
            n_checks++;
            if (num_veh !== 2'(occ)) begin
                n_fail++;
                $display("FAIL occ_up%0d: num_veh %0d, expected %0d", i, num_veh, occ);
            end
        end
        up = 1'b1;
        down = 1'b1;
        @(negedge clk);
        {up, down} = 2'b00;
        n_checks++;
        if (num_veh !== 2'd3) begin
            n_fail++;
            $display("FAIL occ_both: num_veh %0d, expected 3", num_veh);
        end
        down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            occ = (occ > 0) ? occ - 1 : 0;
            n_checks++;
            if (num_veh !== 2'(occ)) begin
                n_fail++;
                $display("FAIL occ_down%0d: num_veh %0d, expected %0d", i, num_veh, occ);
            end
        end
        down = 1'b0;
    endtask

    task automatic test_epass();
        logic [15:0] bal [4] = '{16'd29, 16'd30, 16'd100, 16'd30};
        logic        tag [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        expv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        count = 1'b1;
        for (int i = 0; i < 4; i++) begin
            epass_tag     = tag[i];
            epass_balance = bal[i];
            @(negedge clk);
            n_checks++;
            if (valid_Epass !== expv[i]) begin
                n_fail++;
                $display("FAIL epass_%0d: valid_Epass %0b, expected %0b (bal %0d tag %0b)",
                         i, valid_Epass, expv[i], bal[i], tag[i]);
            end
        end
        count = 1'b0;
        epass_balance = 16'd0;
        @(negedge clk);
        n_checks++;
        if (valid_Epass !== 1'b1) begin
            n_fail++;
            $display("FAIL epass_hold: valid_Epass %0b, expected 1", valid_Epass);
        end
        pulse_init();
        epass_tag = 1'b0;
        n_checks++;
        if (valid_Epass !== 1'b0) begin
            n_fail++;
            $display("FAIL epass_init: valid_Epass %0b, expected 0", valid_Epass);
        end
    endtask

    task automatic test_normal();
        pulse_init();
        do_count(20);
        n_checks++;
        if (elapsed !== 16'd20) begin
            n_fail++;
            $display("FAIL normal_elapsed: elapsed %0d, expected 20", elapsed);
        end
        push_cal();
        // A second cal mid-division must not restart anything.
        repeat (3) @(negedge clk);
        cal = 1'b1;
        @(negedge clk);
        cal = 1'b0;
        wait_done("normal", 40);
    endtask

    task automatic test_overspeed();
        pulse_init();
        do_count(10);
        push_cal();
        wait_done("overspeed", 40);
    endtask

    task automatic test_zero();
        pulse_init();
        push_cal();
        wait_done("zero", 10);
    endtask

    task automatic test_init_wins();
        count = 1'b1;
        init  = 1'b1;
        @(negedge clk);
        init = 1'b0;
        n_checks++;
        if (elapsed !== 16'd0) begin
            n_fail++;
            $display("FAIL init_wins: elapsed %0d, expected 0", elapsed);
        end
        @(negedge clk);
        count = 1'b0;
        n_checks++;
        if (elapsed !== 16'd1) begin
            n_fail++;
            $display("FAIL count_after_init: elapsed %0d, expected 1", elapsed);
        end
        pulse_init();
    endtask

    task automatic test_abort();
        bit seen;
        seen = 1'b0;
        pulse_init();
        do_count(20);
        cal = 1'b1;
        @(negedge clk);
        cal = 1'b0;
        repeat (4) @(negedge clk);
        pulse_init();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_no_done: done seen after init, expected none");
        end
        n_checks++;
        if (speed !== 16'd65535 || fee !== 8'd30 || overspeed !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_hold: speed %0d fee %0d ovs %0b, expected 65535/30/1",
                     speed, fee, overspeed);
        end
        do_count(20);
        push_cal();
        wait_done("after_abort", 40);
    endtask

    task automatic test_async_reset();
        bit seen;
        seen = 1'b0;
        up = 1'b1;
        @(negedge clk);
        up = 1'b0;
        pulse_init();
        epass_tag     = 1'b1;
        epass_balance = 16'd100;
        do_count(20);
        cal = 1'b1;
        @(negedge clk);
        cal = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        occ = 0;
        elapsed_model = 0;
        n_checks++;
        if ({valid_Epass, num_veh, done, elapsed, speed, fee, overspeed} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: vE %0b nv %0d done %0b el %0d sp %0d fee %0d ovs %0b, expected all 0",
                     valid_Epass, num_veh, done, elapsed, speed, fee, overspeed);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        epass_tag = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || speed !== 16'd0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL async_reset_quiet: done or speed changed after reset, expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_occupancy();
        test_epass();
        test_normal();
        test_overspeed();
        test_zero();
        test_init_wins();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
